// File: rtl/hs4_sync_sink.sv
// Clocked sink for the 4-phase rr/ra handshake: synchronises rr, captures rdata, returns ra, presents tokens on valid/ready.
// Optional ring cycle-time measurement is enabled by defining HS4_CYCLE_MEAS_EN.
module hs4_sync_sink #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rr,
  input  logic [DATA_W-1:0] rdata,
  output logic              ra,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  tok_cnt,
  output logic [CNT_W-1:0]  cyc_last,
  output logic              cyc_vld
);

  typedef enum logic [1:0] {IDLE, STALL, ACKH} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rr_s;
  logic                   slot_free;
  logic                   capture;
  logic                   ra_n;

  assign rr_s      = sync[SYNC_STAGES-1];
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], rr};
  end

  always_comb begin
    state_n = state;
    ra_n    = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (rr_s) begin
          if (slot_free) begin
            capture = 1'b1;
            ra_n    = 1'b1;
            state_n = ACKH;
          end else begin
            state_n = STALL;
          end
        end
      end
      STALL: begin
        // rr withdrawn before acknowledge: abandon the request without capturing
        if (!rr_s) begin
          state_n = IDLE;
        end else if (slot_free) begin
          capture = 1'b1;
          ra_n    = 1'b1;
          state_n = ACKH;
        end
      end
      ACKH: begin
        if (rr_s) ra_n    = 1'b1;
        else      state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ra        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tok_cnt   <= '0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      if (capture) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
        tok_cnt   <= tok_cnt + CNT_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef HS4_CYCLE_MEAS_EN
  logic             rr_s_q;
  logic             rise;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign rise    = rr_s && !rr_s_q;
  // cnt restarts at 0 on the rise edge, so clocks elapsed at the next rise = cnt + 1
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_s_q   <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
      cyc_last <= '0;
      cyc_vld  <= 1'b0;
    end else begin
      rr_s_q  <= rr_s;
      cyc_vld <= rise && armed;
      if (rise) begin
        armed <= 1'b1;
        cnt   <= '0;
        if (armed) cyc_last <= cnt_inc;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end
`else
  assign cyc_last = '0;
  assign cyc_vld  = 1'b0;
`endif

endmodule
